reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer.
- Consumes ROB commit writes and new-tail rename notifications.
- Answers decoder source-operand queries, returning either a value or a ROB dependency tag.
- Forwards in-flight values it obtains from the ROB's dependency-query port.

Parameters:
ROB_SIZE_BIT, 5, log2 of ROB entries; width of all ROB tags.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; state frozen when low
clear_flag  input  1  ROB mispredict flush
write_reg_id  input  5  commit destination register (0 = no commit)
write_val  input  32  commit value
write_ROB_id  input  ROB_SIZE_BIT  ROB entry being committed
new_reg_id  input  5  register renamed this cycle (0 = none)
new_ROB_id  input  ROB_SIZE_BIT  ROB tag assigned to new_reg_id
dec_rs1  input  5  decoder source 1 index
dec_rs2  input  5  decoder source 2 index
rs1_val  output  32  source 1 value (valid when rs1_has_dep=0)
rs1_has_dep  output  1  source 1 still waits on ROB entry
rs1_dep  output  ROB_SIZE_BIT  ROB tag source 1 waits on
rs2_val, rs2_has_dep, rs2_dep  output  32/1/ROB_SIZE_BIT  same for source 2
rob_rs1_id  output  ROB_SIZE_BIT  tag query to ROB for source 1
rob_rs1_ready  input  1  ROB reports that entry ready
rob_rs1_val  input  32  ROB entry value
rob_rs2_id, rob_rs2_ready, rob_rs2_val  output/input/input  ROB_SIZE_BIT/1/32  same for source 2

Behaviour:
- State: 32 x {val[31:0], busy, tag[ROB_SIZE_BIT-1:0]}.
- Reset (rst_in=0, async): all val=0, busy=0, tag=0. Outputs are combinational, so during reset: rs*_val=0, rs*_has_dep=0, rs*_dep=0, rob_rs*_id=0.
- rdy_in=0: no state change; combinational outputs still driven.
- clear_flag=1 && rdy_in=1:
  - All busy<=0, tag<=0; val retained.
  - The same-cycle commit and rename are ignored, because the ROB is discarding them.
- Normal cycle (rdy_in=1, clear_flag=0):
  - Commit: if write_reg_id!=0, val[write_reg_id]<=write_val.
  - If additionally busy[write_reg_id] && tag[write_reg_id]==write_ROB_id, then busy<=0. A stale tag mismatch leaves busy=1.
  - Rename: if new_reg_id!=0, busy[new_reg_id]<=1, tag<=new_ROB_id.
  - Same register in commit and rename: val is written, busy stays 1, and tag is the new one (rename wins).
- Register x0: writes and renames ignored; always val=0, busy=0.
- Query (combinational, per source s; rs2 identical):
  - rob_rs_id = tag[dec_rs].
  - If dec_rs==0 or !busy[dec_rs]: val=val[dec_rs], has_dep=0.
  - Else if the commit this cycle matches (write_reg_id==dec_rs && write_ROB_id==tag): val=write_val, has_dep=0.
  - Else if rob_rs_ready: val=rob_rs_val, has_dep=0.
  - Else: has_dep=1, dep=tag, val=0.
- Query sees pre-rename state: the same-cycle rename (the decoder's own rd) never affects its own sources.
- During clear_flag: query still returns val with has_dep=0 (busy treated as cleared).
- Tag wrap-around: tags compared as exact ROB_SIZE_BIT values, no age logic. The ROB guarantees a tag is not reused while live.

Test Plan:
- Reset: pulse rst_in low mid-cycle, then release. Expect dec_rs1=5 gives rs1_val=0, rs1_has_dep=0 immediately (asynchronous).
- Rename and commit: rename x5 with tag 3, next cycle query x5. Expect has_dep=1, dep=3, rob_rs1_id=3. Then commit x5 with tag 3, val 0xDEADBEEF. Expect same-cycle bypass val=0xDEADBEEF; next cycle busy=0.
- Stale commit: rename x7 tag 2, then x7 tag 9, then commit x7 tag 2 val 0x11. Expect val=0x11 stored but has_dep=1, dep=9. Also, if rob_rs1_ready=1 with rob_rs1_val=0x22, expect rs1_val=0x22, has_dep=0.
- Simultaneous: commit x4 tag 1 and rename x4 tag 6 in the same cycle. Expect busy=1, tag=6, val updated.
- x0: rename x0 tag 4, commit x0 val 0x55. Expect query x0 gives 0, has_dep=0.
- Flush/stall: with x3 and x8 busy, assert clear_flag together with commit x3 val 0x99. Expect both busy=0 and x3 val unchanged. Separately, hold rdy_in=0 during a rename: expect no state change.

Source files
------------

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Each register holds a value, a busy flag and the ROB tag of its newest
// in-flight producer. Commits from the ROB write values and clear busy when
// the committing tag is still the newest producer. Renames mark a register
// busy with a fresh tag. Source queries are answered combinationally with a
// value or a ROB dependency tag, using the same-cycle commit and the ROB's
// dependency-query port as bypass paths.
module reg_file_rename #(
    parameter int ROB_SIZE_BIT = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear_flag,
    input  logic [4:0]              write_reg_id,
    input  logic [31:0]             write_val,
    input  logic [ROB_SIZE_BIT-1:0] write_ROB_id,
    input  logic [4:0]              new_reg_id,
    input  logic [ROB_SIZE_BIT-1:0] new_ROB_id,
    input  logic [4:0]              dec_rs1,
    input  logic [4:0]              dec_rs2,
    output logic [31:0]             rs1_val,
    output logic                    rs1_has_dep,
    output logic [ROB_SIZE_BIT-1:0] rs1_dep,
    output logic [31:0]             rs2_val,
    output logic                    rs2_has_dep,
    output logic [ROB_SIZE_BIT-1:0] rs2_dep,
    output logic [ROB_SIZE_BIT-1:0] rob_rs1_id,
    input  logic                    rob_rs1_ready,
    input  logic [31:0]             rob_rs1_val,
    output logic [ROB_SIZE_BIT-1:0] rob_rs2_id,
    input  logic                    rob_rs2_ready,
    input  logic [31:0]             rob_rs2_val
);

    logic [31:0]             reg_val  [0:31];
    logic [ROB_SIZE_BIT-1:0] reg_tag  [0:31];
    logic [31:0]             reg_busy;

    // Register state update: flush clears rename state, otherwise commit
    // then rename (rename is applied last so it wins on the same register).
    // Register x0 is never written, so it stays zero and never busy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                reg_val[i] <= '0;
                reg_tag[i] <= '0;
            end
            reg_busy <= '0;
        end else if (rdy_in) begin
            if (clear_flag) begin
                // The ROB discards this cycle's commit and rename, so only
                // the rename state is wiped; values stay architectural.
                for (int i = 0; i < 32; i++) begin
                    reg_tag[i] <= '0;
                end
                reg_busy <= '0;
            end else begin
                if (write_reg_id != 5'd0) begin
                    reg_val[write_reg_id] <= write_val;
                    // A stale commit (older tag) leaves the newer producer pending.
                    if (reg_busy[write_reg_id] && reg_tag[write_reg_id] == write_ROB_id) begin
                        reg_busy[write_reg_id] <= 1'b0;
                    end
                end
                if (new_reg_id != 5'd0) begin
                    reg_busy[new_reg_id] <= 1'b1;
                    reg_tag[new_reg_id]  <= new_ROB_id;
                end
            end
        end
    end

    // Source 1 lookup against pre-rename state, with commit and ROB bypass.
    always_comb begin
        rob_rs1_id  = reg_tag[dec_rs1];
        rs1_val     = '0;
        rs1_has_dep = 1'b0;
        rs1_dep     = '0;
        if (dec_rs1 == 5'd0 || !reg_busy[dec_rs1] || clear_flag) begin
            rs1_val = reg_val[dec_rs1];
        end else if (write_reg_id == dec_rs1 && write_ROB_id == reg_tag[dec_rs1]) begin
            rs1_val = write_val;
        end else if (rob_rs1_ready) begin
            rs1_val = rob_rs1_val;
        end else begin
            rs1_has_dep = 1'b1;
            rs1_dep     = reg_tag[dec_rs1];
        end
    end

    // Source 2 lookup, identical to source 1.
    always_comb begin
        rob_rs2_id  = reg_tag[dec_rs2];
        rs2_val     = '0;
        rs2_has_dep = 1'b0;
        rs2_dep     = '0;
        if (dec_rs2 == 5'd0 || !reg_busy[dec_rs2] || clear_flag) begin
            rs2_val = reg_val[dec_rs2];
        end else if (write_reg_id == dec_rs2 && write_ROB_id == reg_tag[dec_rs2]) begin
            rs2_val = write_val;
        end else if (rob_rs2_ready) begin
            rs2_val = rob_rs2_val;
        end else begin
            rs2_has_dep = 1'b1;
            rs2_dep     = reg_tag[dec_rs2];
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed rename/commit/flush/stall scenarios
// followed by a short randomized commit-then-read phase. Expected query
// results are pushed when a cycle's stimulus is driven and popped when the
// combinational outputs are sampled.
module tb_reg_file_rename;

    localparam int RB = 5;
    localparam int W  = 32 + 1 + RB + RB;  // {val, has_dep, dep, rob_id}

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_flag;
    logic [4:0]    write_reg_id;
    logic [31:0]   write_val;
    logic [RB-1:0] write_ROB_id;
    logic [4:0]    new_reg_id;
    logic [RB-1:0] new_ROB_id;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic [31:0]   rs1_val;
    logic          rs1_has_dep;
    logic [RB-1:0] rs1_dep;
    logic [31:0]   rs2_val;
    logic          rs2_has_dep;
    logic [RB-1:0] rs2_dep;
    logic [RB-1:0] rob_rs1_id;
    logic          rob_rs1_ready;
    logic [31:0]   rob_rs1_val;
    logic [RB-1:0] rob_rs2_id;
    logic          rob_rs2_ready;
    logic [31:0]   rob_rs2_val;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           src_q[$];

    reg_file_rename #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear_flag   (clear_flag),
        .write_reg_id (write_reg_id),
        .write_val    (write_val),
        .write_ROB_id (write_ROB_id),
        .new_reg_id   (new_reg_id),
        .new_ROB_id   (new_ROB_id),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .rs1_val      (rs1_val),
        .rs1_has_dep  (rs1_has_dep),
        .rs1_dep      (rs1_dep),
        .rs2_val      (rs2_val),
        .rs2_has_dep  (rs2_has_dep),
        .rs2_dep      (rs2_dep),
        .rob_rs1_id   (rob_rs1_id),
        .rob_rs1_ready(rob_rs1_ready),
        .rob_rs1_val  (rob_rs1_val),
        .rob_rs2_id   (rob_rs2_id),
        .rob_rs2_ready(rob_rs2_ready),
        .rob_rs2_val  (rob_rs2_val)
    );

    // Clock: 10 time-unit period, posedge active.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs={val=%h dep_flag=%0b dep=%0d rob_id=%0d} exp={val=%h dep_flag=%0b dep=%0d rob_id=%0d}",
                     tag, obs[W-1 -: 32], obs[2*RB], obs[2*RB-1 -: RB], obs[RB-1:0],
                     exp[W-1 -: 32], exp[2*RB], exp[2*RB-1 -: RB], exp[RB-1:0]);
        end
    endtask

    task automatic set_idle();
        rdy_in        = 1'b1;
        clear_flag    = 1'b0;
        write_reg_id  = '0;
        write_val     = '0;
        write_ROB_id  = '0;
        new_reg_id    = '0;
        new_ROB_id    = '0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        rob_rs1_ready = 1'b0;
        rob_rs1_val   = '0;
        rob_rs2_ready = 1'b0;
        rob_rs2_val   = '0;
    endtask

    // Advance to just after the next active edge and return inputs to idle.
    task automatic tick();
        @(posedge clk_in);
        #1;
        set_idle();
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [RB-1:0] t, input logic [31:0] v);
        write_reg_id = r;
        write_ROB_id = t;
        write_val    = v;
    endtask

    task automatic do_rename(input logic [4:0] r, input logic [RB-1:0] t);
        new_reg_id = r;
        new_ROB_id = t;
    endtask

    task automatic expect_src(input string tag, input int src, input logic [31:0] v,
                              input logic hd, input logic [RB-1:0] dep, input logic [RB-1:0] rid);
        exp_q.push_back({v, hd, dep, rid});
        tag_q.push_back(tag);
        src_q.push_back(src);
    endtask

    // Pop every pending expectation and compare against the live outputs.
    task automatic compare_now();
        logic [W-1:0] e;
        string        t;
        int           s;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            s = src_q.pop_front();
            if (s == 1) check_eq(t, {rs1_val, rs1_has_dep, rs1_dep, rob_rs1_id}, e);
            else        check_eq(t, {rs2_val, rs2_has_dep, rs2_dep, rob_rs2_id}, e);
        end
    endtask

    task automatic sample();
        @(negedge clk_in);
        compare_now();
    endtask

    initial begin
        logic [4:0]  rr;
        logic [31:0] rv;

        set_idle();
        rst_in = 1'b0;

        // Held in reset: combinational outputs read the cleared state.
        #2;
        dec_rs1 = 5'd5;
        dec_rs2 = 5'd31;
        expect_src("reset_rs1", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_src("reset_rs2", 2, 32'h0, 1'b0, 5'd0, 5'd0);
        sample();
        rst_in = 1'b1;
        tick();

        // Rename x5 -> tag 3; the same-cycle query still sees x5 idle.
        do_rename(5'd5, 5'd3);
        dec_rs1 = 5'd5;
        expect_src("rename_pre_state", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        sample();
        tick();

        dec_rs1 = 5'd5;
        expect_src("x5_waits_tag3", 1, 32'h0, 1'b1, 5'd3, 5'd3);
        sample();
        tick();

        // Commit x5 tag 3: same-cycle bypass on both sources.
        do_commit(5'd5, 5'd3, 32'hDEADBEEF);
        dec_rs1 = 5'd5;
        dec_rs2 = 5'd5;
        expect_src("commit_bypass_rs1", 1, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3);
        expect_src("commit_bypass_rs2", 2, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3);
        sample();
        tick();

        dec_rs1 = 5'd5;
        expect_src("x5_committed", 1, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3);
        sample();
        tick();

        // Stale commit: x7 renamed twice, older tag commits.
        do_rename(5'd7, 5'd2);
        tick();
        do_rename(5'd7, 5'd9);
        tick();
        do_commit(5'd7, 5'd2, 32'h11);
        dec_rs2 = 5'd7;
        expect_src("stale_commit_cycle", 2, 32'h0, 1'b1, 5'd9, 5'd9);
        sample();
        tick();

        dec_rs1 = 5'd7;
        expect_src("stale_still_busy", 1, 32'h0, 1'b1, 5'd9, 5'd9);
        sample();
        tick();

        dec_rs1       = 5'd7;
        rob_rs1_ready = 1'b1;
        rob_rs1_val   = 32'h22;
        expect_src("rob_forward", 1, 32'h22, 1'b0, 5'd0, 5'd9);
        sample();
        tick();

        // Simultaneous commit and rename of x4: rename wins on busy/tag.
        do_rename(5'd4, 5'd1);
        tick();
        do_commit(5'd4, 5'd1, 32'h44);
        do_rename(5'd4, 5'd6);
        dec_rs1 = 5'd4;
        expect_src("simul_bypass", 1, 32'h44, 1'b0, 5'd0, 5'd1);
        sample();
        tick();

        dec_rs1 = 5'd4;
        expect_src("simul_busy_tag6", 1, 32'h0, 1'b1, 5'd6, 5'd6);
        sample();
        tick();

        dec_rs2       = 5'd4;
        rob_rs2_ready = 1'b1;
        rob_rs2_val   = 32'h66;
        expect_src("simul_rob_fwd_rs2", 2, 32'h66, 1'b0, 5'd0, 5'd6);
        sample();
        tick();

        // x0 ignores renames and commits.
        do_rename(5'd0, 5'd4);
        do_commit(5'd0, 5'd4, 32'h55);
        tick();
        dec_rs1       = 5'd0;
        dec_rs2       = 5'd0;
        rob_rs1_ready = 1'b1;
        rob_rs1_val   = 32'h77;
        expect_src("x0_rs1", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_src("x0_rs2", 2, 32'h0, 1'b0, 5'd0, 5'd0);
        sample();
        tick();

        // Flush with x3 and x8 busy and a same-cycle commit to x3.
        do_rename(5'd3, 5'd10);
        tick();
        do_rename(5'd8, 5'd11);
        tick();
        clear_flag = 1'b1;
        do_commit(5'd3, 5'd10, 32'h99);
        dec_rs1 = 5'd3;
        dec_rs2 = 5'd8;
        expect_src("flush_cycle_x3", 1, 32'h0, 1'b0, 5'd0, 5'd10);
        expect_src("flush_cycle_x8", 2, 32'h0, 1'b0, 5'd0, 5'd11);
        sample();
        tick();

        dec_rs1 = 5'd3;
        dec_rs2 = 5'd8;
        expect_src("after_flush_x3", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_src("after_flush_x8", 2, 32'h0, 1'b0, 5'd0, 5'd0);
        sample();
        tick();

        // The earlier stale commit value of x7 becomes visible once unbusied.
        dec_rs1 = 5'd7;
        dec_rs2 = 5'd4;
        expect_src("x7_stale_val_kept", 1, 32'h11, 1'b0, 5'd0, 5'd0);
        expect_src("x4_val_kept", 2, 32'h44, 1'b0, 5'd0, 5'd0);
        sample();
        tick();

        // Stall: rename and commit while rdy_in is low change nothing.
        rdy_in = 1'b0;
        do_rename(5'd9, 5'd5);
        do_commit(5'd3, 5'd0, 32'h33);
        tick();
        dec_rs1 = 5'd9;
        dec_rs2 = 5'd3;
        expect_src("stall_no_rename", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_src("stall_no_commit", 2, 32'h0, 1'b0, 5'd0, 5'd0);
        sample();
        tick();

        // Randomized commits to idle registers, read back next cycle.
        for (int i = 0; i < 8; i++) begin
            rr = 5'($urandom_range(1, 31));
            rv = $urandom;
            do_commit(rr, 5'($urandom_range(0, 31)), rv);
            tick();
            dec_rs1 = rr;
            dec_rs2 = rr;
            rob_rs1_ready = 1'b1;
            rob_rs1_val   = ~rv;
            expect_src("rand_commit_rs1", 1, rv, 1'b0, 5'd0, 5'd0);
            expect_src("rand_commit_rs2", 2, rv, 1'b0, 5'd0, 5'd0);
            sample();
            tick();
        end

        // Asynchronous reset pulse mid-cycle clears x5 immediately.
        do_rename(5'd12, 5'd7);
        tick();
        dec_rs1 = 5'd5;
        dec_rs2 = 5'd12;
        #2;
        rst_in = 1'b0;
        #1;
        expect_src("async_reset_x5", 1, 32'h0, 1'b0, 5'd0, 5'd0);
        expect_src("async_reset_x12", 2, 32'h0, 1'b0, 5'd0, 5'd0);
        compare_now();
        #1;
        rst_in = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
